// File: rtl/efuse_seq_ctrl.sv
// eFuse sequencer: read, program (ones only), program+verify, blank check.
// Define EFUSE_SEQ_VERIFY_EN to build the mode-2 read-back and compare.
module efuse_seq_ctrl #(
  parameter int          AW       = 8,
  parameter int          DW       = 8,
  parameter int          NW       = 64,
  parameter logic [15:0] PASSWORD = 16'hA5C3,
  parameter int          SW       = $clog2(2**AW/NW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [15:0]   password,
  input  logic [SW-1:0] sel,
  input  logic [NW-1:0] wdata,
  input  logic [5:0]    trd,
  input  logic [9:0]    tpgm,
  output logic [NW-1:0] rdata,
  output logic          done,
  output logic          busy,
  output logic          err_pwd,
  output logic          vfy_fail,
  output logic          no_blank,
  output logic          efuse_pgmen_o,
  output logic          efuse_rden_o,
  output logic          efuse_aen_o,
  output logic [AW-1:0] efuse_addr_o,
  input  logic [DW-1:0] efuse_rdata_i
);

  localparam int G   = NW / DW;
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam int JW  = $clog2(NW);
  localparam int DSH = $clog2(DW);
  localparam int NSH = $clog2(NW);

  typedef enum logic [3:0] {
    IDLE, CHK, RSET, RSTB, RHLD,
    PSKIP, PSET, PSTB, PHLD, VFY, DONE
  } state_t;

  state_t        state;
  logic [1:0]    mode_l;
  logic [SW-1:0] sel_l;
  logic [NW-1:0] wdata_l;
  logic [5:0]    trd_l;
  logic [9:0]    tpgm_l;
  logic [GW-1:0] g;
  logic [JW-1:0] j;
  logic [9:0]    cnt;

  logic [GW-1:0] g_nx;
  logic [JW-1:0] j_nx;
  logic [AW-1:0] base;
  logic [AW-1:0] rd_addr_nx;
  logic [AW-1:0] pg_addr_nx;
  logic [9:0]    trd_m1;
  logic [9:0]    tpgm_m1;
  logic          last_g;
  logic          last_j;
  logic          prog_mode;
  logic          vfy_path;

  assign g_nx       = g + GW'(1);
  assign j_nx       = j + JW'(1);
  assign base       = AW'(sel_l) << NSH;
  assign rd_addr_nx = base + (AW'(g_nx) << DSH);
  assign pg_addr_nx = base + AW'(j_nx);
  assign trd_m1     = 10'(trd_l) - 10'd1;
  assign tpgm_m1    = tpgm_l - 10'd1;
  assign last_g     = (g == GW'(G - 1));
  assign last_j     = (j == JW'(NW - 1));
  assign prog_mode  = (mode_l == 2'd1) || (mode_l == 2'd2);

`ifdef EFUSE_SEQ_VERIFY_EN
  assign vfy_path = (mode_l == 2'd2);
`else
  assign vfy_path = 1'b0;
  assign vfy_fail = 1'b0;
`endif

  // Sequencer FSM; strobes are registered for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_l        <= '0;
      sel_l         <= '0;
      wdata_l       <= '0;
      trd_l         <= '0;
      tpgm_l        <= '0;
      g             <= '0;
      j             <= '0;
      cnt           <= '0;
      rdata         <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      err_pwd       <= 1'b0;
      no_blank      <= 1'b0;
`ifdef EFUSE_SEQ_VERIFY_EN
      vfy_fail      <= 1'b0;
`endif
      efuse_pgmen_o <= 1'b0;
      efuse_rden_o  <= 1'b0;
      efuse_aen_o   <= 1'b0;
      efuse_addr_o  <= '0;
    end else begin
      done          <= 1'b0;
      efuse_pgmen_o <= 1'b0;
      efuse_rden_o  <= 1'b0;
      efuse_aen_o   <= 1'b0;
      efuse_addr_o  <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_l   <= mode;
            sel_l    <= sel;
            wdata_l  <= wdata;
            trd_l    <= (trd == '0) ? 6'd1 : trd;
            tpgm_l   <= (tpgm == '0) ? 10'd1 : tpgm;
            busy     <= 1'b1;
            err_pwd  <= 1'b0;
            no_blank <= 1'b0;
`ifdef EFUSE_SEQ_VERIFY_EN
            vfy_fail <= 1'b0;
`endif
            state    <= CHK;
          end
        end
        CHK: begin
          if (prog_mode && (password != PASSWORD)) begin
            err_pwd <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else if (prog_mode) begin
            j <= '0;
            if (wdata_l[0]) begin
              efuse_aen_o  <= 1'b1;
              efuse_addr_o <= base;
              state        <= PSET;
            end else begin
              state <= PSKIP;
            end
          end else begin
            g            <= '0;
            efuse_aen_o  <= 1'b1;
            efuse_addr_o <= base;
            state        <= RSET;
          end
        end
        RSET: begin
          cnt           <= '0;
          efuse_aen_o   <= 1'b1;
          efuse_rden_o  <= 1'b1;
          efuse_addr_o  <= efuse_addr_o;
          state         <= RSTB;
        end
        RSTB: begin
          efuse_aen_o  <= 1'b1;
          efuse_addr_o <= efuse_addr_o;
          if (cnt == trd_m1) begin
            rdata[int'(g)*DW +: DW] <= efuse_rdata_i;
            state <= RHLD;
          end else begin
            cnt          <= cnt + 10'd1;
            efuse_rden_o <= 1'b1;
          end
        end
        RHLD: begin
          if (!last_g) begin
            g            <= g_nx;
            efuse_aen_o  <= 1'b1;
            efuse_addr_o <= rd_addr_nx;
            state        <= RSET;
          end else if (vfy_path) begin
            state <= VFY;
          end else begin
            if (mode_l == 2'd3) no_blank <= |rdata;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        PSKIP, PHLD: begin
          if (!last_j) begin
            j <= j_nx;
            if (wdata_l[j_nx]) begin
              efuse_aen_o  <= 1'b1;
              efuse_addr_o <= pg_addr_nx;
              state        <= PSET;
            end else begin
              state <= PSKIP;
            end
          end else if (vfy_path) begin
            g            <= '0;
            efuse_aen_o  <= 1'b1;
            efuse_addr_o <= base;
            state        <= RSET;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        PSET: begin
          cnt           <= '0;
          efuse_aen_o   <= 1'b1;
          efuse_pgmen_o <= 1'b1;
          efuse_addr_o  <= efuse_addr_o;
          state         <= PSTB;
        end
        PSTB: begin
          efuse_aen_o  <= 1'b1;
          efuse_addr_o <= efuse_addr_o;
          if (cnt == tpgm_m1) begin
            state <= PHLD;
          end else begin
            cnt           <= cnt + 10'd1;
            efuse_pgmen_o <= 1'b1;
          end
        end
        VFY: begin
`ifdef EFUSE_SEQ_VERIFY_EN
          vfy_fail <= ((rdata & wdata_l) != wdata_l);
`endif
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// Bench for efuse_seq_ctrl: directed + random transactions vs fuse-array model.
// Expectations follow EFUSE_SEQ_VERIFY_EN when it is defined for the build.
module tb_efuse_seq_ctrl;

  localparam int          AW = 8;
  localparam int          DW = 8;
  localparam int          NW = 64;
  localparam int          SW = 2;
  localparam logic [15:0] PW = 16'hA5C3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [15:0]   password = '0;
  logic [SW-1:0] sel = '0;
  logic [NW-1:0] wdata = '0;
  logic [5:0]    trd = '0;
  logic [9:0]    tpgm = '0;
  logic [NW-1:0] rdata;
  logic          done, busy, err_pwd, vfy_fail, no_blank;
  logic          efuse_pgmen_o, efuse_rden_o, efuse_aen_o;
  logic [AW-1:0] efuse_addr_o;
  logic [DW-1:0] efuse_rdata_i;

  efuse_seq_ctrl #(.AW(AW), .DW(DW), .NW(NW), .PASSWORD(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .password(password), .sel(sel), .wdata(wdata), .trd(trd),
    .tpgm(tpgm), .rdata(rdata), .done(done), .busy(busy),
    .err_pwd(err_pwd), .vfy_fail(vfy_fail), .no_blank(no_blank),
    .efuse_pgmen_o(efuse_pgmen_o), .efuse_rden_o(efuse_rden_o),
    .efuse_aen_o(efuse_aen_o), .efuse_addr_o(efuse_addr_o),
    .efuse_rdata_i(efuse_rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit           pat_mode = 1'b0;
  bit           stuck = 1'b0;
  bit           fuse_clr = 1'b1;
  bit           cnt_clr = 1'b0;
  logic [255:0] fuses;
  logic [255:0] ref_fuse = '0;
  int           pg_cnt[256];
  int           rd_cnt[256];
  int           aen_cyc = 0;

  assign efuse_rdata_i = pat_mode ? (efuse_addr_o ^ 8'h5A)
                                  : fuses[efuse_addr_o +: 8];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Macro model: a programmed bit latches to 1 unless it is the stuck bit.
  always @(posedge clk) begin
    if (fuse_clr) fuses <= '0;
    else if (efuse_pgmen_o && !(stuck && efuse_addr_o == 8'd2))
      fuses[efuse_addr_o] <= 1'b1;
  end

  // Strobe monitor: per-address strobe counts and bus rules.
  always @(negedge clk) begin
    if (cnt_clr) begin
      for (int i = 0; i < 256; i++) begin
        pg_cnt[i] <= 0;
        rd_cnt[i] <= 0;
      end
      aen_cyc <= 0;
    end else if (rst_n) begin
      if (efuse_pgmen_o) pg_cnt[efuse_addr_o] <= pg_cnt[efuse_addr_o] + 1;
      if (efuse_rden_o) rd_cnt[efuse_addr_o] <= rd_cnt[efuse_addr_o] + 1;
      if (efuse_aen_o) aen_cyc <= aen_cyc + 1;
      chk("strobe_excl", 64'(efuse_pgmen_o & efuse_rden_o), 64'd0);
      chk("idle_bus", 64'(!efuse_aen_o && (efuse_addr_o != '0 ||
          efuse_pgmen_o || efuse_rden_o)), 64'd0);
    end
  end

  function automatic int exp_lat(logic [1:0] m, logic [63:0] w,
                                 logic [5:0] tr, logic [9:0] tg);
    int te, tp, ones, rl, pl;
    te = (tr == 0) ? 1 : int'(tr);
    tp = (tg == 0) ? 1 : int'(tg);
    ones = $countones(w);
    rl = 8 * (te + 2);
    pl = 2 + (64 - ones) + ones * (tp + 2);
    if (m == 2'd0 || m == 2'd3) return 2 + rl;
    if (m == 2'd1) return pl;
`ifdef EFUSE_SEQ_VERIFY_EN
    return pl + rl + 1;
`else
    return pl;
`endif
  endfunction

  task automatic prog_ref(input logic [1:0] s, input logic [63:0] w);
    logic [255:0] m;
    m = 256'(w) << (int'(s) * 64);
    if (stuck) m[2] = 1'b0;
    ref_fuse = ref_fuse | m;
  endtask

  task automatic clear_fuses();
    @(posedge clk); #1 fuse_clr = 1'b1;
    @(posedge clk); #1 fuse_clr = 1'b0;
    ref_fuse = '0;
  endtask

  task automatic run(input logic [1:0] m, input logic [15:0] pw,
                     input logic [1:0] s, input logic [63:0] w,
                     input logic [5:0] tr, input logic [9:0] tg,
                     input bit noise, output int lat);
    bit ok;
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    mode = m; password = pw; sel = s; wdata = w;
    trd = tr; tpgm = tg; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (noise) begin
      mode = ~m; sel = ~s; wdata = ~w; trd = tr + 6'd5; tpgm = tg + 10'd7;
    end
    lat = 1;
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (noise) start = (lat == 3 || lat == 5);
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 64'(ok), 64'd1);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_off", 64'(busy), 64'd0);
  endtask

  task automatic prog_chk(input logic [1:0] s, input logic [63:0] w,
                          input logic [9:0] tg);
    logic [255:0] mask;
    int sum, tp;
    tp = (tg == 0) ? 1 : int'(tg);
    sum = 0;
    mask = '0;
    for (int i = 0; i < 256; i++) begin
      mask[i] = (pg_cnt[i] != 0);
      sum += pg_cnt[i];
    end
    chk("pg_mask", mask[int'(s)*64 +: 64], w);
    chk("pg_sum", 64'(sum), 64'($countones(w) * tp));
    chk("fuse_word", fuses[int'(s)*64 +: 64], ref_fuse[int'(s)*64 +: 64]);
  endtask

  task automatic rd_chk(input logic [1:0] s, input logic [5:0] tr);
    int te, sum;
    te = (tr == 0) ? 1 : int'(tr);
    sum = 0;
    for (int i = 0; i < 256; i++) sum += rd_cnt[i];
    chk("rd_sum", 64'(sum), 64'(8 * te));
    for (int gi = 0; gi < 8; gi++)
      chk("rd_grp", 64'(rd_cnt[int'(s)*64 + gi*8]), 64'(te));
  endtask

  initial begin
    int lat;
    logic [63:0] e;
    logic [1:0] m, s;
    logic [63:0] w;
    logic [5:0] tr;
    logic [9:0] tg;
    logic [15:0] pw;
    bit dseen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_flags", 64'({done, busy, err_pwd, vfy_fail, no_blank}), 64'd0);
    chk("rst_bus", 64'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o,
                        efuse_addr_o}), 64'd0);
    fuse_clr = 1'b0;
    rst_n = 1'b1;

    pat_mode = 1'b1;
    run(2'd0, 16'h0, 2'd2, 64'd0, 6'd3, 10'd0, 1'b0, lat);
    chk("rd_lat", 64'(lat), 64'd42);
    for (int gi = 0; gi < 8; gi++) e[gi*8 +: 8] = 8'(128 + gi*8) ^ 8'h5A;
    chk("rd_data", rdata, e);
    rd_chk(2'd2, 6'd3);
    pat_mode = 1'b0;

    run(2'd1, PW, 2'd0, 64'h5, 6'd0, 10'd10, 1'b0, lat);
    prog_ref(2'd0, 64'h5);
    chk("pg_lat", 64'(lat), 64'd88);
    chk("pg_a0", 64'(pg_cnt[0]), 64'd10);
    chk("pg_a2", 64'(pg_cnt[2]), 64'd10);
    prog_chk(2'd0, 64'h5, 10'd10);

    run(2'd1, 16'h0000, 2'd1, 64'hFF, 6'd1, 10'd1, 1'b0, lat);
    chk("pwd_lat", 64'(lat), 64'd2);
    chk("pwd_err", 64'(err_pwd), 64'd1);
    chk("pwd_aen", 64'(aen_cyc), 64'd0);
    chk("pwd_fuse", fuses[127:64], 64'd0);

    clear_fuses();
    stuck = 1'b1;
    run(2'd2, PW, 2'd0, 64'h5, 6'd2, 10'd10, 1'b0, lat);
    prog_ref(2'd0, 64'h5);
    chk("vfy_errclr", 64'(err_pwd), 64'd0);
    chk("vfy_lat", 64'(lat), 64'(exp_lat(2'd2, 64'h5, 6'd2, 10'd10)));
    prog_chk(2'd0, 64'h5, 10'd10);
`ifdef EFUSE_SEQ_VERIFY_EN
    chk("vfy_fail_st", 64'(vfy_fail), 64'd1);
    chk("vfy_rdata", rdata, 64'h1);
`else
    chk("vfy_fail_off", 64'(vfy_fail), 64'd0);
`endif
    stuck = 1'b0;

    clear_fuses();
    run(2'd2, PW, 2'd0, 64'h5, 6'd2, 10'd10, 1'b0, lat);
    prog_ref(2'd0, 64'h5);
    chk("vfy_ok", 64'(vfy_fail), 64'd0);
    chk("vfy_lat2", 64'(lat), 64'(exp_lat(2'd2, 64'h5, 6'd2, 10'd10)));
`ifdef EFUSE_SEQ_VERIFY_EN
    chk("vfy_rdata2", rdata, 64'h5);
`else
    chk("vfy_as_pg", 64'(lat), 64'd88);
`endif

    clear_fuses();
    run(2'd3, 16'h0, 2'd3, 64'd0, 6'd1, 10'd0, 1'b0, lat);
    chk("blank_lat", 64'(lat), 64'd26);
    chk("blank0", 64'(no_blank), 64'd0);
    chk("blank0_rd", rdata, 64'd0);
    run(2'd1, PW, 2'd3, 64'h8000_0000_0000_0000, 6'd0, 10'd1, 1'b0, lat);
    prog_ref(2'd3, 64'h8000_0000_0000_0000);
    prog_chk(2'd3, 64'h8000_0000_0000_0000, 10'd1);
    run(2'd3, 16'h0, 2'd3, 64'd0, 6'd1, 10'd0, 1'b0, lat);
    chk("blank1", 64'(no_blank), 64'd1);
    chk("blank1_rd", rdata, 64'h8000_0000_0000_0000);

    run(2'd0, 16'h0, 2'd3, 64'd0, 6'd2, 10'd0, 1'b1, lat);
    chk("noise_lat", 64'(lat), 64'd34);
    chk("noise_rd", rdata, ref_fuse[255:192]);
    rd_chk(2'd3, 6'd2);

    run(2'd0, 16'h0, 2'd3, 64'd0, 6'd0, 10'd0, 1'b0, lat);
    chk("trd0_lat", 64'(lat), 64'd26);
    rd_chk(2'd3, 6'd0);

    for (int it = 0; it < 10; it++) begin
      m = 2'($urandom_range(0, 3));
      s = 2'($urandom_range(0, 3));
      w = {$urandom, $urandom} & {$urandom, $urandom};
      tr = 6'($urandom_range(0, 3));
      tg = 10'($urandom_range(0, 3));
      pw = ($urandom_range(0, 3) == 0) ? 16'h1234 : PW;
      run(m, pw, s, w, tr, tg, 1'b0, lat);
      if ((m == 2'd1 || m == 2'd2) && pw != PW) begin
        chk("r_pwd_lat", 64'(lat), 64'd2);
        chk("r_pwd_err", 64'(err_pwd), 64'd1);
        chk("r_pwd_aen", 64'(aen_cyc), 64'd0);
      end else begin
        chk("r_lat", 64'(lat), 64'(exp_lat(m, w, tr, tg)));
        chk("r_err", 64'(err_pwd), 64'd0);
        if (m == 2'd1 || m == 2'd2) begin
          prog_ref(s, w);
          prog_chk(s, w, tg);
        end
        if (m == 2'd0 || m == 2'd3)
          chk("r_rdata", rdata, ref_fuse[int'(s)*64 +: 64]);
        if (m == 2'd3)
          chk("r_blank", 64'(no_blank),
              64'(|ref_fuse[int'(s)*64 +: 64]));
`ifdef EFUSE_SEQ_VERIFY_EN
        if (m == 2'd2) begin
          chk("r_vrd", rdata, ref_fuse[int'(s)*64 +: 64]);
          chk("r_vfy", 64'(vfy_fail), 64'd0);
        end
`endif
      end
    end

    @(posedge clk); #1;
    mode = 2'd1; password = PW; sel = 2'd0; wdata = 64'h1;
    tpgm = 10'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dseen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (efuse_pgmen_o) break;
    end
    chk("pstb_seen", 64'(efuse_pgmen_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pgmen", 64'(efuse_pgmen_o), 64'd0);
    chk("rst_aen", 64'(efuse_aen_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) dseen = 1'b1;
    end
    chk("rst_nodone", 64'(dseen), 64'd0);
    chk("rst_rdata2", rdata, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
